// File: rtl/cache_sa.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement,
// blocking miss handling over a handshaked backing-memory port and saturating hit/miss counters.
module cache_sa #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              rd_wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic              resp_valid,
   output logic [DATA_W-1:0] read_data,
   output logic              hit_miss,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

   state_t state;

   logic [SETS-1:0]   valid_q [WAYS];
   logic [SETS-1:0]   dirty_q [WAYS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [DATA_W-1:0] data_q  [WAYS][SETS];
   logic [WAY_W-1:0]  age_q   [WAYS][SETS];

   logic              req_wr;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [DATA_W-1:0] req_wdata;

   logic [WAY_W-1:0]  sel_way;
   logic [WAY_W-1:0]  sel_age;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_hit;

   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  oldest_way;
   logic [WAY_W-1:0]  oldest_age;
   logic [WAY_W-1:0]  victim_way;

   logic              unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];

   // Tag match and victim choice for the latched request: first invalid way, else the oldest.
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      inv_found  = 1'b0;
      inv_way    = '0;
      oldest_way = '0;
      oldest_age = age_q[0][req_idx];
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!inv_found && !valid_q[w][req_idx]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_q[w][req_idx] > oldest_age) begin
            oldest_age = age_q[w][req_idx];
            oldest_way = WAY_W'(w);
         end
      end
      victim_way = inv_found ? inv_way : oldest_way;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         hit_miss   <= 1'b0;
         read_data  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         req_wr     <= 1'b0;
         req_tag    <= '0;
         req_idx    <= '0;
         req_wdata  <= '0;
         sel_way    <= '0;
         sel_age    <= '0;
         rsp_data   <= '0;
         rsp_hit    <= 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
            for (int s = 0; s < SETS; s++) begin
               age_q[w][s] <= '0;
            end
         end
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_wr    <= rd_wr;
                  req_tag   <= address[ADDR_W-1:2+IDX_W];
                  req_idx   <= address[2+IDX_W-1:2];
                  req_wdata <= write_data;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  sel_way <= hit_way;
                  sel_age <= age_q[hit_way][req_idx];
                  rsp_hit <= 1'b1;
                  if (req_wr) begin
                     data_q[hit_way][req_idx]  <= req_wdata;
                     dirty_q[hit_way][req_idx] <= 1'b1;
                  end else begin
                     rsp_data <= data_q[hit_way][req_idx];
                  end
                  if (hit_count != {CNT_W{1'b1}}) begin
                     hit_count <= hit_count + 1'b1;
                  end
                  state <= RESPOND;
               end else begin
                  // A filled line ages every other way, so freshly filled sets keep distinct ages.
                  sel_way <= victim_way;
                  sel_age <= WAY_W'(WAYS - 1);
                  rsp_hit <= 1'b0;
                  if (miss_count != {CNT_W{1'b1}}) begin
                     miss_count <= miss_count + 1'b1;
                  end
                  mem_req <= 1'b1;
                  if (valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {tag_q[victim_way][req_idx], req_idx, 2'b00};
                     mem_wdata <= data_q[victim_way][req_idx];
                     state     <= WRITEBACK;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= {req_tag, req_idx, 2'b00};
                     state    <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= REFILL;
               end
            end
            REFILL: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, req_idx, 2'b00};
               end else if (mem_ack) begin
                  mem_req                   <= 1'b0;
                  tag_q[sel_way][req_idx]   <= req_tag;
                  valid_q[sel_way][req_idx] <= 1'b1;
                  if (req_wr) begin
                     data_q[sel_way][req_idx]  <= req_wdata;
                     dirty_q[sel_way][req_idx] <= 1'b1;
                  end else begin
                     data_q[sel_way][req_idx]  <= mem_rdata;
                     dirty_q[sel_way][req_idx] <= 1'b0;
                     rsp_data                  <= mem_rdata;
                  end
                  state <= RESPOND;
               end
            end
            RESPOND: begin
               resp_valid <= 1'b1;
               hit_miss   <= rsp_hit;
               if (!req_wr) begin
                  read_data <= rsp_data;
               end
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == sel_way) begin
                     age_q[w][req_idx] <= '0;
                  end else if (age_q[w][req_idx] < sel_age) begin
                     age_q[w][req_idx] <= age_q[w][req_idx] + 1'b1;
                  end
               end
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa: a recency-ordered cache model predicts responses and memory
// traffic, a compare process checks every response, and literal expectations pin key scenarios.
module tb_cache_sa;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int SETS    = 16;
   localparam int WAYS    = 2;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              rd_wr;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic              resp_valid;
   logic [DATA_W-1:0] read_data;
   logic              hit_miss;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   cache_sa #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .rd_wr(rd_wr),
      .address(address), .write_data(write_data),
      .resp_valid(resp_valid), .read_data(read_data), .hit_miss(hit_miss),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_op_t;

   typedef struct {
      bit          hit;
      logic [31:0] rdata;
      int          hits;
      int          misses;
   } resp_t;

   bit          m_valid [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   logic [31:0] m_line  [SETS][WAYS];
   logic [31:0] m_data  [SETS][WAYS];
   int          m_used  [SETS][WAYS];
   int          m_time;
   int          m_hits;
   int          m_misses;
   logic [31:0] m_last_rd;
   bit          model_hit;

   mem_op_t     exp_mem  [$];
   resp_t       exp_resp [$];
   logic [31:0] backing  [int];

   bit          mem_enable;
   int          n_wb;
   int          n_refill;
   logic [31:0] last_wb_addr;
   logic [31:0] last_wb_data;
   logic [31:0] last_refill_addr;
   int          last_lat;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (backing.exists(int'(a))) return backing[int'(a)];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic void modelReset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_used[s][w]  = 0;
         end
      end
      m_hits    = 0;
      m_misses  = 0;
      m_last_rd = '0;
      exp_mem.delete();
      exp_resp.delete();
   endfunction

   // Cache semantics by recency: each set keeps at most WAYS lines; a miss in a full set
   // evicts the line used longest ago and writes it back only if it was modified.
   function automatic void modelAccess(input bit wr, input logic [31:0] a, input logic [31:0] wd);
      int          s;
      int          way;
      int          victim;
      resp_t       r;
      mem_op_t     op;
      logic [31:0] line;
      line = {a[31:2], 2'b00};
      s    = int'((line >> 2) % SETS);
      way  = -1;
      for (int i = 0; i < WAYS; i++) begin
         if (m_valid[s][i] && m_line[s][i] == line) way = i;
      end
      m_time++;
      if (way >= 0) begin
         r.hit = 1'b1;
         if (m_hits < CNT_MAX) m_hits++;
         if (wr) begin
            m_data[s][way]  = wd;
            m_dirty[s][way] = 1'b1;
         end else begin
            m_last_rd = m_data[s][way];
         end
      end else begin
         r.hit = 1'b0;
         if (m_misses < CNT_MAX) m_misses++;
         victim = -1;
         for (int i = 0; i < WAYS; i++) begin
            if (!m_valid[s][i] && victim < 0) victim = i;
         end
         if (victim < 0) begin
            victim = 0;
            for (int i = 1; i < WAYS; i++) begin
               if (m_used[s][i] < m_used[s][victim]) victim = i;
            end
            if (m_dirty[s][victim]) begin
               op.we   = 1'b1;
               op.addr = m_line[s][victim];
               op.data = m_data[s][victim];
               exp_mem.push_back(op);
               backing[int'(m_line[s][victim])] = m_data[s][victim];
            end
         end
         op.we   = 1'b0;
         op.addr = line;
         op.data = '0;
         exp_mem.push_back(op);
         m_valid[s][victim] = 1'b1;
         m_line[s][victim]  = line;
         m_dirty[s][victim] = wr;
         m_data[s][victim]  = wr ? wd : memRead(line);
         if (!wr) m_last_rd = memRead(line);
         way = victim;
      end
      m_used[s][way] = m_time;
      r.rdata  = m_last_rd;
      r.hits   = m_hits;
      r.misses = m_misses;
      exp_resp.push_back(r);
      model_hit = r.hit;
   endfunction

   // Backing memory: acknowledges any request in the first cycle it is seen and checks it.
   mem_op_t cur_op;
   always @(negedge clk) begin
      if (reset && mem_enable && mem_req && !mem_ack) begin
         if (exp_mem.size() == 0) begin
            checkOutput("mem_unexpected_req", 32'(mem_req), 32'd0);
         end else begin
            cur_op = exp_mem.pop_front();
            checkOutput("mem_we", 32'(mem_we), 32'(cur_op.we));
            checkOutput("mem_addr", mem_addr, cur_op.addr);
            if (cur_op.we) checkOutput("mem_wdata", mem_wdata, cur_op.data);
         end
         if (mem_we) begin
            n_wb++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
         end else begin
            n_refill++;
            last_refill_addr = mem_addr;
         end
         mem_rdata = memRead(mem_addr);
         mem_ack   = 1'b1;
      end else begin
         mem_ack = 1'b0;
      end
   end

   resp_t cur_resp;
   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_resp.size() == 0) begin
            checkOutput("resp_unexpected", 32'(resp_valid), 32'd0);
         end else begin
            cur_resp = exp_resp.pop_front();
            checkOutput("resp_hit_miss", 32'(hit_miss), 32'(cur_resp.hit));
            checkOutput("resp_read_data", read_data, cur_resp.rdata);
            checkOutput("resp_hit_count", 32'(hit_count), 32'(cur_resp.hits));
            checkOutput("resp_miss_count", 32'(miss_count), 32'(cur_resp.misses));
         end
      end
   end

   task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] wd);
      int lat;
      modelAccess(wr, a, wd);
      @(negedge clk);
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      rd_wr      = wr;
      address    = a;
      write_data = wd;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      last_lat = lat;
      if (!resp_valid) begin
         checkOutput("resp_timeout", 32'(resp_valid), 32'd1);
      end else if (model_hit) begin
         checkOutput("hit_latency", 32'(lat), 32'd2);
      end else begin
         checkOutput("miss_latency_min3", 32'(lat >= 3), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset      = 1'b0;
      req_valid  = 1'b0;
      rd_wr      = 1'b0;
      address    = '0;
      write_data = '0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      mem_enable = 1'b1;
      n_wb       = 0;
      n_refill   = 0;
      m_time     = 0;
      last_wb_addr     = '0;
      last_wb_data     = '0;
      last_refill_addr = '0;
      modelReset();

      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
      checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_read_data", read_data, 32'd0);

      $display("[TB] read 0x08 twice");
      applyStimulus(1'b0, 32'h08, 32'h0);
      checkOutput("s2_first_hit_miss", 32'(hit_miss), 32'd0);
      checkOutput("s2_refill_addr", last_refill_addr, 32'h08);
      checkOutput("s2_refills", 32'(n_refill), 32'd1);
      applyStimulus(1'b0, 32'h08, 32'h0);
      checkOutput("s2_second_hit_miss", 32'(hit_miss), 32'd1);
      checkOutput("s2_second_data", read_data, 32'h5A5A_0008);
      checkOutput("s2_second_latency", 32'(last_lat), 32'd2);
      checkOutput("s2_hit_count", 32'(hit_count), 32'd1);
      checkOutput("s2_miss_count", 32'(miss_count), 32'd1);

      $display("[TB] write-allocate 0x48 then read back");
      applyStimulus(1'b1, 32'h48, 32'h0033_3333);
      checkOutput("s3_write_hit_miss", 32'(hit_miss), 32'd0);
      checkOutput("s3_write_holds_rdata", read_data, 32'h5A5A_0008);
      applyStimulus(1'b0, 32'h48, 32'h0);
      checkOutput("s3_read_hit_miss", 32'(hit_miss), 32'd1);
      checkOutput("s3_read_data", read_data, 32'h0033_3333);

      $display("[TB] conflict in set 2");
      applyStimulus(1'b0, 32'h08, 32'h0);
      applyStimulus(1'b0, 32'h88, 32'h0);
      checkOutput("s4_wb_count", 32'(n_wb), 32'd1);
      checkOutput("s4_wb_addr", last_wb_addr, 32'h48);
      checkOutput("s4_wb_data", last_wb_data, 32'h0033_3333);
      checkOutput("s4_refill_addr", last_refill_addr, 32'h88);
      checkOutput("s4_read_data", read_data, 32'h5A5A_0088);
      applyStimulus(1'b0, 32'hC8, 32'h0);
      checkOutput("s4_clean_no_wb", 32'(n_wb), 32'd1);
      checkOutput("s4_clean_refill", last_refill_addr, 32'hC8);
      checkOutput("s4_hit_count", 32'(hit_count), 32'd3);
      checkOutput("s4_miss_count", 32'(miss_count), 32'd4);

      $display("[TB] reset during refill");
      @(negedge clk);
      mem_enable = 1'b0;
      req_valid  = 1'b1;
      rd_wr      = 1'b0;
      address    = 32'h14;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("s5_mem_req_seen", 32'(mem_req), 32'd1);
      @(negedge clk);
      checkOutput("s5_no_resp_withheld", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("s5_mem_req_drop", 32'(mem_req), 32'd0);
      checkOutput("s5_no_resp", 32'(resp_valid), 32'd0);
      modelReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("s5_req_ready", 32'(req_ready), 32'd1);
      checkOutput("s5_hit_count", 32'(hit_count), 32'd0);
      checkOutput("s5_miss_count", 32'(miss_count), 32'd0);
      mem_enable = 1'b1;
      applyStimulus(1'b0, 32'h08, 32'h0);
      checkOutput("s5_read_misses", 32'(hit_miss), 32'd0);
      checkOutput("s5_read_data", read_data, 32'h5A5A_0008);

      $display("[TB] hit counter saturation");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b0, 32'h08, 32'h0);
      end
      checkOutput("s6_hit_count_sat", 32'(hit_count), 32'd15);
      checkOutput("s6_miss_count", 32'(miss_count), 32'd1);

      repeat (3) @(negedge clk);
      checkOutput("end_resp_queue_empty", 32'(exp_resp.size()), 32'd0);
      checkOutput("end_mem_queue_empty", 32'(exp_mem.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
